// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher helpers: round-mode encodings, GF(2^8) multiplies (modulus 0x11b)
// and the InvShiftRows / InvMixColumns transforms on a FIPS-197 column-major 128-bit state.
package aes_pkg;

    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_FINAL   = 2'd1,
        MODE_KEYONLY = 2'd2,
        MODE_RSVD    = 2'd3
    } aes_mode_e;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
                gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
                gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mixw(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+4-row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_pipe_if.sv
// Beat handshake between the key scheduler side, the inverse round pipe and the round controller.
interface aes_inv_round_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_block;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_block;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_block, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_block, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_block, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_block, out_tag, out_err
    );
endinterface

// File: rtl/aes_inv_mixcolumns.sv
// Combinational InvMixColumns over all four columns; also used by the equivalent-inverse key path.
module aes_inv_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] state,
    output logic [127:0] result
);
    assign result = inv_mixcolumns(state);
endmodule

// File: rtl/aes_inv_round_pipe.sv
// One AES inverse round per beat in four register stages sharing a single advance signal;
// the inverse S-box sits outside and is looked up combinationally from the stage-1 register.
module aes_inv_round_pipe
    import aes_pkg::*;
#(
    parameter int TAG_W        = 4,
    parameter bit KEY_AT_ENTRY = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_inv_round_pipe_if.slave bus,
    input  logic [127:0]        round_key,
    output logic [127:0]        sbox_in,
    input  logic [127:0]        sbox_out,
    output logic [2:0]          occupancy
);

    logic             s1_valid, s2_valid, s3_valid, s4_valid;
    aes_mode_e        s1_mode, s2_mode, s3_mode, s4_mode;
    logic [127:0]     s1_data, s2_data, s3_data, s4_data;
    logic [127:0]     s1_key, s2_key;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;

    logic             adv;
    logic             accept;
    logic             drain;
    aes_mode_e        in_mode_e;
    logic [127:0]     s1_next, s2_next, s3_next, s4_next;
    logic [127:0]     stage3_key;
    logic [127:0]     mix_result;
    logic [2:0]       valid_count;

    assign adv       = !s4_valid || bus.out_ready;
    assign accept    = bus.in_valid && adv;
    assign drain     = s4_valid && bus.out_ready;
    assign in_mode_e = aes_mode_e'(bus.in_mode);

    assign bus.in_ready  = adv;
    assign bus.out_valid = s4_valid;
    assign bus.out_block = s4_data;
    assign bus.out_tag   = s4_tag;
    assign bus.out_err   = s4_valid && (s4_mode == MODE_RSVD);
    assign sbox_in       = s1_data;

    aes_inv_mixcolumns u_mix (
        .state  (s3_data),
        .result (mix_result)
    );

    // Key-only beats bypass the permutation and substitution; final beats skip the column mix.
    always_comb begin
        s1_next    = (in_mode_e == MODE_KEYONLY) ? bus.in_block : inv_shiftrows(bus.in_block);
        s2_next    = (s1_mode == MODE_KEYONLY) ? s1_data : sbox_out;
        stage3_key = KEY_AT_ENTRY ? s2_key : round_key;
        s3_next    = s2_data ^ stage3_key;
        s4_next    = (s3_mode == MODE_NORMAL || s3_mode == MODE_RSVD) ? mix_result : s3_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s1_mode  <= MODE_NORMAL;
            s2_mode  <= MODE_NORMAL;
            s3_mode  <= MODE_NORMAL;
            s4_mode  <= MODE_NORMAL;
            s1_data  <= '0;
            s2_data  <= '0;
            s3_data  <= '0;
            s4_data  <= '0;
            s1_key   <= '0;
            s2_key   <= '0;
            s1_tag   <= '0;
            s2_tag   <= '0;
            s3_tag   <= '0;
            s4_tag   <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_mode  <= in_mode_e;
            s1_data  <= s1_next;
            s1_key   <= KEY_AT_ENTRY ? round_key : '0;
            s1_tag   <= bus.in_tag;

            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_data  <= s2_next;
            s2_key   <= s1_key;
            s2_tag   <= s1_tag;

            s3_valid <= s2_valid;
            s3_mode  <= s2_mode;
            s3_data  <= s3_next;
            s3_tag   <= s2_tag;

            s4_valid <= s3_valid;
            s4_mode  <= s3_mode;
            s4_data  <= s4_next;
            s4_tag   <= s3_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else begin
            case ({accept, drain})
                2'b10:   occupancy <= occupancy + 3'd1;
                2'b01:   occupancy <= occupancy - 3'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign valid_count = 3'(s1_valid) + 3'(s2_valid) + 3'(s3_valid) + 3'(s4_valid);

    occupancy_matches_valids: assert property (
        @(posedge clk) disable iff (!reset_n) occupancy == valid_count
    );

endmodule

// File: tb/tb_aes_inv_round_pipe.sv
// Scoreboard bench for aes_inv_round_pipe: directed FIPS-197 vectors, backpressure, reserved mode
// and mid-flight reset, with a behavioural inverse S-box standing in for the external block.
module tb_aes_inv_round_pipe;

    typedef struct packed {
        logic [127:0] block;
        logic [3:0]   tag;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [127:0] round_key;
    logic [127:0] sbox_in;
    logic [127:0] sbox_out;
    logic [2:0]   occupancy;

    int   checks = 0;
    int   errors = 0;
    int   outputs_seen = 0;
    int   seen_before;
    int   lat;
    logic [127:0] held_block;
    exp_t exp_q[$];

    aes_inv_round_pipe_if #(.TAG_W(4)) bus ();

    aes_inv_round_pipe #(
        .TAG_W        (4),
        .KEY_AT_ENTRY (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .round_key (round_key),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq, acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    always_comb begin
        sbox_out = '0;
        for (int i = 0; i < 16; i++) begin
            sbox_out[127-8*i -: 8] = inv_sbox(sbox_in[127-8*i -: 8]);
        end
    end

    task automatic checkVal(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkVal("out_block", bus.out_block, e.block);
        checkVal("out_tag", 128'(bus.out_tag), 128'(e.tag));
        checkVal("out_err", 128'(bus.out_err), 128'(e.err));
    endtask

    // Drives one beat, waits (bounded) for acceptance, and records the expected result.
    task automatic applyStimulus(input logic [127:0] blk, input logic [1:0] mode, input logic [3:0] tag,
                                 input logic [127:0] key, input logic [127:0] exp_blk);
        int   waited;
        exp_t e;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
        round_key    = key;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready still %0b after %0d cycles, expected 1", bus.in_ready, waited);
        end else begin
            e.block = exp_blk;
            e.tag   = tag;
            e.err   = (mode == 2'd3);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || occupancy != 3'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every transfer; any output with nothing pending is an error.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                outputs_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got tag %0d block %h, expected no beat", bus.out_tag, bus.out_block);
                end else begin
                    checkOutput(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        round_key     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkVal("reset_out_valid", 128'(bus.out_valid), 128'd0);
        checkVal("reset_out_block", bus.out_block, 128'd0);
        checkVal("reset_out_tag", 128'(bus.out_tag), 128'd0);
        checkVal("reset_out_err", 128'(bus.out_err), 128'd0);
        checkVal("reset_occupancy", 128'(occupancy), 128'd0);
        checkVal("reset_sbox_in", sbox_in, 128'd0);
        checkVal("reset_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;

        $display("[TB] key-only beat and latency");
        applyStimulus(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2'd2, 4'd1,
                      128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        checkVal("latency", 128'(lat), 128'd4);
        waitDrain();

        $display("[TB] normal round with inverse S-box");
        applyStimulus(128'h7ad5fda789ef4e272bca100b3d9ff59f, 2'd0, 4'd2,
                      128'h549932d1f08557681093ed9cbe2c974e, 128'h54d990a16ba09ab596bbf40ea111702f);
        @(negedge clk);
        checkVal("sbox_in", sbox_in, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
        waitDrain();

        $display("[TB] final round");
        applyStimulus(128'h6353e08c0960e104cd70b751bacad0e7, 2'd1, 4'd3,
                      128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        waitDrain();

        $display("[TB] reserved mode followed by normal mode");
        applyStimulus(128'h7ad5fda789ef4e272bca100b3d9ff59f, 2'd3, 4'd4,
                      128'h549932d1f08557681093ed9cbe2c974e, 128'h54d990a16ba09ab596bbf40ea111702f);
        applyStimulus(128'h7ad5fda789ef4e272bca100b3d9ff59f, 2'd0, 4'd5,
                      128'h549932d1f08557681093ed9cbe2c974e, 128'h54d990a16ba09ab596bbf40ea111702f);
        waitDrain();

        $display("[TB] back-to-back with backpressure");
        seen_before = outputs_seen;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus({16{8'(16 + i)}}, 2'd2, 4'(i), {16{8'(3 * i)}},
                                  {16{8'(16 + i) ^ 8'(3 * i)}});
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(negedge clk);
                held_block = bus.out_block;
                checkVal("stall_tag", 128'(bus.out_tag), 128'd1);
                checkVal("stall_occupancy", 128'(occupancy), 128'd4);
                for (int k = 1; k < 4; k++) begin
                    @(negedge clk);
                    checkVal("stall_in_ready", 128'(bus.in_ready), 128'd0);
                    checkVal("stall_out_valid", 128'(bus.out_valid), 128'd1);
                    checkVal("stall_block_hold", bus.out_block, held_block);
                    checkVal("stall_tag_hold", 128'(bus.out_tag), 128'd1);
                    checkVal("stall_occupancy", 128'(occupancy), 128'd4);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        waitDrain();
        checkVal("burst_output_count", 128'(outputs_seen - seen_before), 128'd6);

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus({16{8'(8'ha0 + i)}}, 2'd2, 4'(8 + i), '0, {16{8'(8'ha0 + i)}});
        end
        @(negedge clk);
        checkVal("pre_reset_occupancy", 128'(occupancy), 128'd3);
        #1 reset_n = 1'b0;
        #1;
        checkVal("reset_edge_occupancy", 128'(occupancy), 128'd0);
        checkVal("reset_edge_out_valid", 128'(bus.out_valid), 128'd0);
        exp_q.delete();
        seen_before = outputs_seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkVal("post_reset_in_ready", 128'(bus.in_ready), 128'd1);
        repeat (10) @(negedge clk);
        checkVal("post_reset_occupancy", 128'(occupancy), 128'd0);
        checkVal("post_reset_no_stale", 128'(outputs_seen - seen_before), 128'd0);
        @(posedge clk);
        #1;

        $display("[TB] beat after reset");
        applyStimulus(128'h6353e08c0960e104cd70b751bacad0e7, 2'd1, 4'd15,
                      128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
